// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM states and latched-command record for the byte-serial ALU sequencer.
package alu_seq_pkg;

  localparam int MAX_BYTES_DEF = 4;

  localparam logic [3:0] OP_OR   = 4'b1100;
  localparam logic [3:0] OP_AND  = 4'b1101;
  localparam logic [3:0] OP_EOR  = 4'b1110;
  localparam logic [3:0] OP_PASS = 4'b1111;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0111;
  localparam logic [3:0] OP_ASL  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] op;
    logic       right;
    logic       ci;
    logic       bcd;
    logic [1:0] len;
  } cmd_t;

endpackage

// File: rtl/alu_seq.sv
// Feeds a multi-byte operation one byte per cycle through an external registered 8-bit ALU,
// chaining carry and reassembling the result bytes plus C/Z/N/V flags.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [3:0]             cmd_op,
  input  logic                   cmd_right,
  input  logic                   cmd_ci,
  input  logic                   cmd_bcd,
  input  logic [1:0]             cmd_len,
  input  logic [8*MAX_BYTES-1:0] cmd_a,
  input  logic [8*MAX_BYTES-1:0] cmd_b,
  input  logic                   hold,
  output logic [3:0]             alu_op,
  output logic                   alu_right,
  output logic [7:0]             alu_ai,
  output logic [7:0]             alu_bi,
  output logic                   alu_ci,
  output logic                   alu_bcd,
  output logic                   alu_rdy,
  input  logic [7:0]             alu_out,
  input  logic                   alu_co,
  input  logic                   alu_v,
  output logic                   res_valid,
  output logic [8*MAX_BYTES-1:0] res_data,
  output logic                   res_c,
  output logic                   res_z,
  output logic                   res_n,
  output logic                   res_v
);

  state_t state_q, state_d;
  cmd_t   cmd_q;

  logic [MAX_BYTES-1:0][7:0] a_q, b_q, data_q, data_cap;
  logic [1:0] cnt_q;   // bytes issued so far in this operation
  logic [1:0] slot_q;  // byte slot issued on the previous edge
  logic [1:0] phys;
  logic       v_len_q;
  logic       run_go, drain_go, accept;

  assign cmd_ready = reset_n && (state_q == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign run_go    = (state_q == ST_RUN) && !hold;
  assign drain_go  = (state_q == ST_DRAIN) && !hold;
  assign phys      = cmd_q.right ? (cmd_q.len - cnt_q) : cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (cmd_valid) state_d = ST_RUN;
      ST_RUN:   if (!hold && (cnt_q == cmd_q.len)) state_d = ST_DRAIN;
      ST_DRAIN: if (!hold) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // result bytes as they will look once the ALU's current output lands in its slot
  always_comb begin
    data_cap         = data_q;
    data_cap[slot_q] = alu_out;
  end

  assign alu_op    = cmd_q.op;
  assign alu_right = cmd_q.right;
  assign alu_bcd   = cmd_q.bcd && (cmd_q.op == OP_ADD);
  assign alu_rdy   = run_go;
  assign alu_ai    = (state_q == ST_RUN) ? a_q[phys] : 8'h00;
  assign alu_bi    = (state_q == ST_RUN) ? b_q[phys] : 8'h00;
  // carry chains straight from the ALU's registered CO, so no bubble between bytes
  assign alu_ci    = (state_q == ST_RUN) && ((cnt_q == 2'd0) ? cmd_q.ci : alu_co);

  assign res_data  = data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      slot_q    <= '0;
      v_len_q   <= 1'b0;
      res_valid <= 1'b0;
      res_c     <= 1'b0;
      res_z     <= 1'b0;
      res_n     <= 1'b0;
      res_v     <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_valid <= 1'b0;
      if (accept) begin
        cmd_q.op    <= cmd_op;
        cmd_q.right <= cmd_right;
        cmd_q.ci    <= cmd_ci;
        cmd_q.bcd   <= cmd_bcd;
        cmd_q.len   <= cmd_len;
        a_q         <= cmd_a;
        b_q         <= cmd_b;
        data_q      <= '0;
        cnt_q       <= '0;
        slot_q      <= '0;
        v_len_q     <= 1'b0;
      end
      if (run_go) begin
        if (cnt_q != 2'd0) begin
          data_q <= data_cap;
          if (slot_q == cmd_q.len) v_len_q <= alu_v;
        end
        slot_q <= phys;
        cnt_q  <= cnt_q + 2'd1;
      end
      if (drain_go) begin
        data_q    <= data_cap;
        res_valid <= 1'b1;
        res_c     <= alu_co;
        res_z     <= (data_cap == '0);
        res_n     <= data_cap[cmd_q.len][7];
        res_v     <= (slot_q == cmd_q.len) ? alu_v : v_len_q;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq: a stub registered ALU plus a word-level reference model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_op = '0;
  logic          cmd_right = 1'b0, cmd_ci = 1'b0, cmd_bcd = 1'b0;
  logic [1:0]    cmd_len = '0;
  logic [31:0]   cmd_a = '0, cmd_b = '0;
  logic          hold = 1'b0;
  logic [3:0]    alu_op;
  logic          alu_right, alu_ci, alu_bcd, alu_rdy;
  logic [7:0]    alu_ai, alu_bi;
  logic [7:0]    alu_out;
  logic          alu_co, alu_v;
  logic          res_valid, res_c, res_z, res_n, res_v;
  logic [31:0]   res_data;

  alu_seq #(.MAX_BYTES(MB)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_right(cmd_right), .cmd_ci(cmd_ci), .cmd_bcd(cmd_bcd),
    .cmd_len(cmd_len), .cmd_a(cmd_a), .cmd_b(cmd_b), .hold(hold),
    .alu_op(alu_op), .alu_right(alu_right), .alu_ai(alu_ai), .alu_bi(alu_bi),
    .alu_ci(alu_ci), .alu_bcd(alu_bcd), .alu_rdy(alu_rdy),
    .alu_out(alu_out), .alu_co(alu_co), .alu_v(alu_v),
    .res_valid(res_valid), .res_data(res_data),
    .res_c(res_c), .res_z(res_z), .res_n(res_n), .res_v(res_v)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stub 8-bit ALU: result registered on edges with alu_rdy; returns {v, co, out}.
  function automatic logic [9:0] alu_fn(input logic [3:0] op, input logic right,
                                        input logic [7:0] ai, input logic [7:0] bi,
                                        input logic ci, input logic bcd);
    logic [8:0] s;
    logic [7:0] l, bx;
    logic [4:0] lo, hi;
    logic       c1, c2;
    if (bcd) begin
      lo = {1'b0, ai[3:0]} + {1'b0, bi[3:0]} + {4'b0, ci};
      c1 = lo > 5'd9;
      if (c1) lo = lo + 5'd6;
      hi = {1'b0, ai[7:4]} + {1'b0, bi[7:4]} + {4'b0, c1};
      c2 = hi > 5'd9;
      if (c2) hi = hi + 5'd6;
      return {1'b0, c2, hi[3:0], lo[3:0]};
    end
    case (op)
      OP_ADD, OP_SUB: begin
        bx = (op == OP_SUB) ? ~bi : bi;
        s  = {1'b0, ai} + {1'b0, bx} + {8'b0, ci};
        return {(ai[7] == bx[7]) && (s[7] != ai[7]), s[8], s[7:0]};
      end
      OP_ASL: return {1'b0, ai[7], ai[6:0], ci};
      default: begin
        case (op)
          OP_OR:   l = ai | bi;
          OP_AND:  l = ai & bi;
          OP_EOR:  l = ai ^ bi;
          default: l = ai;
        endcase
        if (right) return {1'b0, l[0], ci, l[7:1]};
        return {1'b0, ci, l};
      end
    endcase
  endfunction

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      alu_out <= '0; alu_co <= 1'b0; alu_v <= 1'b0;
    end else if (alu_rdy) begin
      {alu_v, alu_co, alu_out} <= alu_fn(alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd);
    end

  // Word-level reference: whole-operand arithmetic, decimal via integer conversion.
  typedef struct packed { logic [31:0] d; logic c, z, n, v; } exp_t;

  function automatic exp_t ref_op(input logic [3:0] op, input logic right, input logic ci,
                                  input logic bcd, input logic [1:0] len,
                                  input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    int nb;
    longint unsigned mask, msb, am, bm, s, lg, da, db, lim;
    nb   = 8 * (int'(len) + 1);
    mask = (64'd1 << nb) - 64'd1;
    msb  = 64'd1 << (nb - 1);
    am   = {32'd0, a} & mask;
    bm   = {32'd0, b} & mask;
    r    = '0;
    s    = 0;
    if (op == OP_ADD && bcd) begin
      da = 0; db = 0; lim = 1;
      for (int i = nb/4 - 1; i >= 0; i--) begin
        da  = da * 10 + ((am >> (4*i)) & 64'hF);
        db  = db * 10 + ((bm >> (4*i)) & 64'hF);
        lim = lim * 10;
      end
      s   = da + db + {63'd0, ci};
      r.c = (s >= lim);
      s   = s % lim;
      lg  = 0;
      for (int i = 0; i < nb/4; i++) begin
        lg = lg | ((s % 10) << (4*i));
        s  = s / 10;
      end
      s = lg;
    end else begin
      case (op)
        OP_ADD, OP_SUB: begin
          if (op == OP_SUB) bm = ~bm & mask;
          s   = am + bm + {63'd0, ci};
          r.c = ((s >> nb) & 64'd1) != 0;
          r.v = ((am & msb) == (bm & msb)) && ((s & msb) != (am & msb));
        end
        OP_ASL: begin
          s   = (am << 1) | {63'd0, ci};
          r.c = (am & msb) != 0;
        end
        default: begin
          case (op)
            OP_OR:   lg = am | bm;
            OP_AND:  lg = am & bm;
            OP_EOR:  lg = am ^ bm;
            default: lg = am;
          endcase
          if (right) begin
            s   = (lg >> 1) | (ci ? msb : 64'd0);
            r.c = lg[0];
          end else begin
            s   = lg;
            r.c = ci;
          end
        end
      endcase
    end
    s   = s & mask;
    r.d = s[31:0];
    r.z = (s == 0);
    r.n = (s & msb) != 0;
    return r;
  endfunction

  // Timing model: m_rem = edges (with hold low) still owed before the result pulse.
  int          m_rem;
  logic        m_pulse, m_have;
  exp_t        m_exp, m_last;
  logic [3:0]  m_op;
  logic        m_right, m_ci, m_bcd;
  logic [1:0]  m_len;
  logic [31:0] m_a, m_b;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m_rem <= 0; m_pulse <= 1'b0; m_have <= 1'b0; m_last <= '0;
    end else begin
      m_pulse <= 1'b0;
      if (m_rem == 0) begin
        if (cmd_valid) begin
          m_op <= cmd_op; m_right <= cmd_right; m_ci <= cmd_ci; m_bcd <= cmd_bcd;
          m_len <= cmd_len; m_a <= cmd_a; m_b <= cmd_b;
          m_exp <= ref_op(cmd_op, cmd_right, cmd_ci, cmd_bcd, cmd_len, cmd_a, cmd_b);
          m_rem <= int'(cmd_len) + 2;
        end
      end else if (!hold) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_pulse <= 1'b1; m_last <= m_exp; m_have <= 1'b1;
        end
      end
    end

  always @(negedge clk) begin : cmp
    int k, ph;
    if (reset_n) begin
      chk("cmd_ready", cmd_ready, m_rem == 0);
      chk("alu_rdy", alu_rdy, (m_rem >= 2) && !hold);
      chk("res_valid", res_valid, m_pulse);
      if (m_rem >= 2 && !hold) begin
        k  = int'(m_len) + 2 - m_rem;
        ph = m_right ? int'(m_len) - k : k;
        chk("alu_ai", alu_ai, (m_a >> (8*ph)) & 32'hFF);
        chk("alu_bi", alu_bi, (m_b >> (8*ph)) & 32'hFF);
        chk("alu_ci", alu_ci, (k == 0) ? m_ci : alu_co);
        chk("alu_bcd", alu_bcd, m_bcd && (m_op == OP_ADD));
        chk("alu_op", alu_op, m_op);
      end
      if (m_rem == 0) begin
        chk("res_data", res_data, m_have ? m_last.d : 32'd0);
        chk("res_c", res_c, m_have && m_last.c);
        chk("res_z", res_z, m_have && m_last.z);
        chk("res_n", res_n, m_have && m_last.n);
        chk("res_v", res_v, m_have && m_last.v);
      end
    end
  end

  // Called #1 after an edge with the DUT idle; returns #1 after the accept edge.
  task automatic issue_cmd(input logic [3:0] op, input logic right, input logic ci,
                           input logic bcd, input logic [1:0] len,
                           input logic [31:0] a, input logic [31:0] b);
    cmd_valid = 1'b1; cmd_op = op; cmd_right = right; cmd_ci = ci; cmd_bcd = bcd;
    cmd_len = len; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic right, input logic ci,
                        input logic bcd, input logic [1:0] len,
                        input logic [31:0] a, input logic [31:0] b,
                        input bit stall, input int hold_edge, output int lat);
    bit done;
    done = 1'b0;
    lat  = 0;
    issue_cmd(op, right, ci, bcd, len, a, b);
    for (int e = 0; e < 60 && !done; e++) begin
      if (hold_edge >= 0) hold = (e >= hold_edge) && (e < hold_edge + 2);
      else if (stall)     hold = ($urandom_range(0, 3) == 0);
      if (stall) begin
        cmd_valid = (m_rem >= 1) && ($urandom_range(0, 1) == 1);
        cmd_op = 4'($urandom); cmd_a = $urandom; cmd_b = $urandom;
        cmd_len = 2'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (m_pulse) done = 1'b1;
    end
    hold = 1'b0;
    cmd_valid = 1'b0;
    chk("res_valid_seen", done, 1);
  endtask

  task automatic run_lit(input string name, input logic [3:0] op, input logic right,
                         input logic ci, input logic bcd, input logic [1:0] len,
                         input logic [31:0] a, input logic [31:0] b, input int hold_edge,
                         input logic [31:0] ed, input logic ec, input logic ez,
                         input logic en, input int elat);
    int lat;
    run_op(op, right, ci, bcd, len, a, b, 1'b0, hold_edge, lat);
    chk({name, "_lat"}, lat, elat);
    chk({name, "_data"}, res_data, ed);
    chk({name, "_c"}, res_c, ec);
    chk({name, "_z"}, res_z, ez);
    chk({name, "_n"}, res_n, en);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_res_valid"}, res_valid, 0);
    chk({name, "_res_data"}, res_data, 0);
    chk({name, "_flags"}, {res_c, res_z, res_n, res_v}, 0);
    chk({name, "_alu_rdy"}, alu_rdy, 0);
    chk({name, "_alu_drive"}, {alu_op, alu_right, alu_ai, alu_bi, alu_ci, alu_bcd}, 0);
  endtask

  function automatic logic [31:0] rand_bcd();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  logic [3:0] ops [7] = '{OP_OR, OP_AND, OP_EOR, OP_PASS, OP_ADD, OP_SUB, OP_ASL};

  initial begin
    exp_t e;
    int lat;
    logic [3:0] op;
    logic right, ci, bcd;
    logic [1:0] len;
    logic [31:0] a, b;

    // reference model pinned to hand-worked values
    e = ref_op(OP_ADD, 1'b0, 1'b0, 1'b0, 2'd1, 32'h01FF, 32'h0001);
    chk("model_add", {e.d, e.c, e.z, e.n}, {32'h0200, 3'b000});
    e = ref_op(OP_SUB, 1'b0, 1'b1, 1'b0, 2'd3, 32'h0, 32'h1);
    chk("model_sub", {e.d, e.c, e.z, e.n}, {32'hFFFFFFFF, 3'b001});
    e = ref_op(OP_PASS, 1'b1, 1'b1, 1'b0, 2'd1, 32'h8001, 32'h0);
    chk("model_ror", {e.d, e.c}, {32'hC000, 1'b1});
    e = ref_op(OP_ADD, 1'b0, 1'b0, 1'b1, 2'd1, 32'h0999, 32'h0001);
    chk("model_bcd", {e.d, e.c}, {32'h1000, 1'b0});

    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_lit("add16",  OP_ADD,  1'b0, 1'b0, 1'b0, 2'd1, 32'h01FF, 32'h0001, -1, 32'h0200, 0, 0, 0, 3);
    run_lit("sub32",  OP_SUB,  1'b0, 1'b1, 1'b0, 2'd3, 32'h0, 32'h1, -1, 32'hFFFFFFFF, 0, 0, 1, 5);
    run_lit("ror16",  OP_PASS, 1'b1, 1'b1, 1'b0, 2'd1, 32'h8001, 32'h0, -1, 32'hC000, 1, 0, 1, 3);
    run_lit("asl16",  OP_ASL,  1'b0, 1'b0, 1'b0, 2'd1, 32'h8000, 32'h0, -1, 32'h0000, 1, 1, 0, 3);
    run_lit("bcd16",  OP_ADD,  1'b0, 1'b0, 1'b1, 2'd1, 32'h0999, 32'h0001, -1, 32'h1000, 0, 0, 0, 3);
    run_lit("hold32", OP_ADD,  1'b0, 1'b0, 1'b0, 2'd3, 32'h12345678, 32'h0FEDCBA9, 1,
            32'h22222221, 0, 0, 0, 7);
    run_lit("len0",   OP_EOR,  1'b0, 1'b1, 1'b0, 2'd0, 32'hFFFFFF5A, 32'hFFFFFFA5, -1,
            32'h000000FF, 1, 0, 1, 2);

    // abort mid-operation
    issue_cmd(OP_ADD, 1'b0, 1'b0, 1'b0, 2'd3, 32'h11111111, 32'h22222222);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk_zero_outputs("abort");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", cmd_ready, 1);
    @(posedge clk); #1;
    run_lit("post_abort", OP_ADD, 1'b0, 1'b0, 1'b0, 2'd1, 32'h01FF, 32'h0001, -1, 32'h0200, 0, 0, 0, 3);

    for (int t = 0; t < 300; t++) begin
      op    = ops[$urandom_range(0, 6)];
      len   = 2'($urandom_range(0, 3));
      ci    = 1'($urandom_range(0, 1));
      bcd   = 1'($urandom_range(0, 1));
      right = (op[3:2] == 2'b11) ? 1'($urandom_range(0, 1)) : 1'b0;
      a     = $urandom;
      b     = $urandom;
      if (op == OP_ADD && bcd) begin a = rand_bcd(); b = rand_bcd(); end
      repeat ($urandom_range(0, 2)) begin
        hold = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      hold = 1'b0;
      run_op(op, right, ci, bcd, len, a, b, 1'b1, -1, lat);
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 4, meaning maximum operand length in bytes.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports cmd_valid input 1 / cmd_ready output 1  command handshake.
REQ-005 SHALL have ports cmd_op input 4 (ALU op code), cmd_right input 1 (rotate right), cmd_ci input 1 (initial carry), cmd_bcd input 1, cmd_len input 2 (byte count minus 1).
REQ-006 SHALL have ports cmd_a, cmd_b  input  8*MAX_BYTES  operands, byte 0 = LSB.
REQ-007 SHALL have ports hold  input  1  stall request, freezes sequencing and ALU.
REQ-008 SHALL have ALU drive ports alu_op output 4, alu_right output 1, alu_ai output 8, alu_bi output 8, alu_ci output 1, alu_bcd output 1, alu_rdy output 1.
REQ-009 SHALL have ALU return ports alu_out input 8, alu_co input 1, alu_v input 1 (registered ALU results, valid the cycle after an edge with alu_rdy=1).
REQ-010 SHALL have result ports res_valid output 1 (one-cycle pulse), res_data output 8*MAX_BYTES, res_c, res_z, res_n, res_v output 1 each.

Function
REQ-011 SHALL implement states IDLE, RUN, DRAIN; cmd_ready=1 only in IDLE.
REQ-012 SHALL latch all cmd_* fields and move IDLE->RUN on an edge with cmd_valid & cmd_ready; cmd_valid outside IDLE ignored.
REQ-013 SHALL issue one byte per cycle in RUN with alu_rdy=1: LSB-first when cmd_right=0, MSB-first when cmd_right=1, over cmd_len+1 bytes.
REQ-014 SHALL drive alu_ci=latched cmd_ci for the first byte and alu_ci=alu_co for every later byte (carry chained through ALU's registered CO, no extra cycle).
REQ-015 SHALL drive alu_op/alu_right from latched command; alu_bcd=cmd_bcd only when cmd_op=0011, else 0.
REQ-016 SHALL capture alu_out into the byte slot issued on the previous edge, in the cycle after each issue; RUN->DRAIN after last issue; DRAIN captures final byte then ->IDLE.
REQ-017 SHALL pulse res_valid one cycle, exactly cmd_len+2 rising edges after the accept edge when hold=0.
REQ-018 SHALL set res_c=final captured alu_co; res_z=1 iff all cmd_len+1 result bytes are zero; res_n=bit 7 of result byte cmd_len; res_v=alu_v captured with byte cmd_len.
REQ-019 SHALL zero res_data bytes above cmd_len.
REQ-020 SHALL, while hold=1, force alu_rdy=0 and freeze state, byte index and capture; resumption continues exactly; hold in IDLE has no effect on cmd_ready.
REQ-021 SHALL hold res_data and flags stable from res_valid until the next accept.
REQ-022 SHALL drive alu_rdy=0 in IDLE.

Reset
REQ-023 SHALL, on reset_n low (any time, incl. mid-operation), go to IDLE and clear res_data, res_valid, res_c/z/n/v, all alu_* outputs, and latched command to 0; cmd_ready=1 after release.
REQ-024 SHALL not emit res_valid for an operation aborted by reset.

Structure
REQ-025 SHALL place ALU op constants (OR 1100, AND 1101, EOR 1110, PASS 1111, ADD 0011, SUB 0111, ASL 1011), the state enum, and MAX_BYTES default in shared package alu_seq_pkg.
REQ-026 SHALL contain no sub-module; the ALU is instantiated by the parent and wired to the alu_* ports.

Verification
REQ-027 ADD len=1, A=0x01FF, B=0x0001, ci=0 -> res_data=0x0200, c=0, z=0, n=0, res_valid 3 edges after accept.
REQ-028 SUB len=3, A=0x00000000, B=0x00000001, ci=1 -> res_data=0xFFFFFFFF, c=0, n=1, z=0.
REQ-029 PASS right len=1, A=0x8001, ci=1 -> res_data=0xC000, c=1; ASL len=1, A=0x8000, ci=0 -> 0x0000, c=1, z=1.
REQ-030 ADD bcd len=1, A=0x0999, B=0x0001, ci=0 -> res_data=0x1000, c=0.
REQ-031 hold=1 for 2 cycles after first issue of 4-byte ADD -> identical result, res_valid delayed 2 cycles, alu_rdy=0 during hold.
REQ-032 reset_n low during RUN -> all outputs 0 immediately, no res_valid, cmd_ready=1 after release, next command correct.
